// File: rtl/sram_resp_if.sv
// sram_resp_if -- initiator/responder bundle for the sram_resp block.
//
// Signals:
//   sram_en     access strobe from the initiator
//   sram_wen    byte write enables, bit i selects sram_wdata[8i+7:8i]
//   sram_addr   byte address, bits [1:0] ignored by the responder
//   sram_wdata  write data
//   sram_rdata  registered read data, valid one cycle after the access
//
// Modports: master (initiator side), slave (the sram_resp block).
interface sram_resp_if;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    modport master (
        output sram_en, sram_wen, sram_addr, sram_wdata,
        input  sram_rdata
    );

    modport slave (
        input  sram_en, sram_wen, sram_addr, sram_wdata,
        output sram_rdata
    );
endinterface

// File: rtl/sram_resp.sv
// sram_resp -- single-port, byte-writable SRAM responder mapped at a fixed
// byte window [BASE, BASE + 4*DEPTH). Reads are read-first with a fixed
// one-cycle latency. Accesses outside the window are dropped, return zero
// and are logged in sticky error registers.
//
// Optional feature: define SRAM_RESP_CLEAR_EN to zero the whole memory with
// a one-word-per-cycle sweep after every reset; busy is high during it.
// Without the macro busy is tied low and memory powers up undefined.
//
// Parameters:
//   ADDR_W    word-address width, DEPTH = 2**ADDR_W 32-bit words
//   BASE      byte base of the window, aligned to 4*DEPTH
// Ports:
//   clk       clock, all state changes on the rising edge
//   reset     synchronous, active-high reset
//   bus       sram_resp_if slave modport (strobe, enables, address, data)
//   busy      high while the clear sweep runs
//   err       sticky out-of-window flag
//   err_addr  address of the first out-of-window access since reset
//   err_cnt   saturating count of out-of-window accesses
module sram_resp #(
    parameter int unsigned ADDR_W = 12,
    parameter logic [31:0] BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    sram_resp_if.slave  bus,
    output logic        busy,
    output logic        err,
    output logic [31:0] err_addr,
    output logic [15:0] err_cnt
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] widx;
    logic              in_win;
    logic              acc;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_idx;

    // Byte-offset bits carry no information for a word-wide memory.
    wire unused_addr_bits = &{1'b0, bus.sram_addr[1:0]};

    assign widx   = bus.sram_addr[ADDR_W+1:2];
    assign in_win = (bus.sram_addr[31:ADDR_W+2] == BASE[31:ADDR_W+2]);
    // An accepted access: strobed, not swept, not held in reset.
    assign acc    = bus.sram_en && !busy && !reset;

`ifdef SRAM_RESP_CLEAR_EN
    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] idx;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            idx   <= '0;
            busy  <= 1'b1;
        end else if (state == CLEAR) begin
            idx <= idx + 1'b1;
            if (idx == '1) begin
                state <= RUN;
                busy  <= 1'b0;
            end
        end
    end

    // The sweep stalls while reset is held, so a reset restarts it at 0.
    assign clr_we  = (state == CLEAR) && !reset;
    assign clr_idx = idx;
`else
    assign busy    = 1'b0;
    assign clr_we  = 1'b0;
    assign clr_idx = '0;
`endif

    // NOTE: the memory array has no reset branch; resetting it would turn
    // the RAM into flops. Zeroing is done by the clear sweep when enabled.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_idx] <= '0;
        end else if (acc && in_win) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.sram_wen[i]) begin
                    mem[widx][8*i +: 8] <= bus.sram_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read-first: this samples mem before the same-edge write lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.sram_rdata <= '0;
        end else if (busy) begin
            bus.sram_rdata <= '0;
        end else if (bus.sram_en) begin
            bus.sram_rdata <= in_win ? mem[widx] : 32'h0000_0000;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err      <= 1'b0;
            err_addr <= '0;
            err_cnt  <= '0;
        end else if (acc && !in_win) begin
            err <= 1'b1;
            if (!err) begin
                err_addr <= bus.sram_addr;
            end
            if (err_cnt != 16'hFFFF) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end

endmodule
